// File: rtl/fft_bfly_r2_stage0.sv
// Radix-2 DIT butterfly for FFT column 0 (twiddle W0 = 1): x = a + b, y = a - b.
// Four identical component lanes feed a single output register with a valid qualifier.

module fft_bfly_r2_lane #(
  parameter int DW       = 32,
  parameter int SCALE    = 0,
  parameter int SATURATE = 0,
  parameter bit SUB      = 1'b0
) (
  input  logic [DW-1:0] p,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] r,
  output logic          ovf
);
  logic [DW:0] s;

  always_comb begin
    s   = SUB ? ({p[DW-1], p} - {q[DW-1], q}) : ({p[DW-1], p} + {q[DW-1], q});
    r   = s[DW-1:0];
    ovf = 1'b0;
    if (SCALE != 0) begin
      // Halving the DW+1 bit sum always fits in DW bits.
      r = s[DW:1];
    end else begin
      ovf = s[DW] ^ s[DW-1];
      if ((SATURATE != 0) && ovf)
        r = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
endmodule

module fft_bfly_r2_stage0 #(
  parameter int DW       = 32,
  parameter int SCALE    = 0,
  parameter int SATURATE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [2*DW-1:0] a,
  input  logic [2*DW-1:0] b,
  output logic          out_valid,
  output logic [2*DW-1:0] x,
  output logic [2*DW-1:0] y,
  output logic          ovf
);
  localparam int NUM_LANES = 4;
  localparam int STAGES    = 1;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  cplx_t a_c, b_c, x_d, y_d, x_q, y_q;
  logic [NUM_LANES-1:0][DW-1:0] opa, opb, res;
  logic [NUM_LANES-1:0]         lane_ovf;
  logic [STAGES-1:0]            vld_pipe;
  logic                         ovf_q;

  assign a_c = a;
  assign b_c = b;

  // Lane order {xr, xi, yr, yi}; the two low lanes subtract.
  assign opa = {a_c.re, a_c.im, a_c.re, a_c.im};
  assign opb = {b_c.re, b_c.im, b_c.re, b_c.im};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fft_bfly_r2_lane #(
      .DW(DW), .SCALE(SCALE), .SATURATE(SATURATE), .SUB(g < 2)
    ) u_lane (
      .p(opa[g]), .q(opb[g]), .r(res[g]), .ovf(lane_ovf[g])
    );
  end

  assign x_d = {res[3], res[2]};
  assign y_d = {res[1], res[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_pipe[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (in_valid) begin
        x_q   <= x_d;
        y_q   <= y_d;
        ovf_q <= |lane_ovf;
      end
    end
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign x         = x_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_fft_bfly_r2_stage0.sv
// Directed bench for fft_bfly_r2_stage0: default, saturating and scaling builds share stimulus.

module tb_fft_bfly_r2_stage0;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [2*DW-1:0] a, b;
  logic          ov_d, ov_s, ov_c;
  logic [2*DW-1:0] x_d, y_d, x_s, y_s, x_c, y_c;
  logic          f_d, f_s, f_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_bfly_r2_stage0 #(.DW(DW), .SCALE(0), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov_d), .x(x_d), .y(y_d), .ovf(f_d));

  fft_bfly_r2_stage0 #(.DW(DW), .SCALE(0), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov_s), .x(x_s), .y(y_s), .ovf(f_s));

  fft_bfly_r2_stage0 #(.DW(DW), .SCALE(1), .SATURATE(0)) dut_scl (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov_c), .x(x_c), .y(y_c), .ovf(f_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] cx(input logic [31:0] re, input logic [31:0] im);
    return {re, im};
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    step();
    step();
    chk("rst_ov",  ov_d, 0);
    chk("rst_x",   x_d,  0);
    chk("rst_y",   y_d,  0);
    chk("rst_ovf", f_d,  0);
    chk("rst_ov_scl", ov_c, 0);

    // release and first capture
    rst_n = 1'b1;
    a = cx(32'd5, 0);
    b = cx(32'd3, 0);
    step();
    chk("first_ov",  ov_d, 1);
    chk("first_x",   x_d,  cx(32'd8, 0));
    chk("first_y",   y_d,  cx(32'd2, 0));
    chk("first_ovf", f_d,  0);

    // signed operands
    a = cx(32'hFFFFFFF6, 32'h00000004);
    b = cx(32'h00000007, 32'hFFFFFFFE);
    step();
    chk("sgn_x",   x_d, cx(32'hFFFFFFFD, 32'h00000002));
    chk("sgn_y",   y_d, cx(32'hFFFFFFEF, 32'h00000006));
    chk("sgn_ovf", f_d, 0);

    // positive overflow
    a = cx(32'h7FFFFFFF, 0);
    b = cx(32'h00000001, 0);
    step();
    chk("povf_x",     x_d, cx(32'h80000000, 0));
    chk("povf_y",     y_d, cx(32'h7FFFFFFE, 0));
    chk("povf_ovf",   f_d, 1);
    chk("povf_sat_x", x_s, cx(32'h7FFFFFFF, 0));
    chk("povf_sat_y", y_s, cx(32'h7FFFFFFE, 0));
    chk("povf_sat_f", f_s, 1);
    chk("povf_scl_x", x_c, cx(32'h40000000, 0));
    chk("povf_scl_y", y_c, cx(32'h3FFFFFFF, 0));
    chk("povf_scl_f", f_c, 0);

    // negative overflow from most-negative input
    a = cx(32'h80000000, 0);
    b = cx(32'h00000001, 0);
    step();
    chk("novf_x",     x_d, cx(32'h80000001, 0));
    chk("novf_y",     y_d, cx(32'h7FFFFFFF, 0));
    chk("novf_ovf",   f_d, 1);
    chk("novf_sat_y", y_s, cx(32'h80000000, 0));
    chk("novf_scl_x", x_c, cx(32'hC0000000, 0));
    chk("novf_scl_y", y_c, cx(32'hBFFFFFFF, 0));

    // imaginary-only overflow still raises the flag
    a = cx(0, 32'h80000000);
    b = cx(0, 32'h80000000);
    step();
    chk("iovf_x",   x_d, cx(0, 0));
    chk("iovf_ovf", f_d, 1);
    chk("iovf_sat", x_s, cx(0, 32'h80000000));

    // A == B and B == 0
    a = cx(32'h12345678, 32'h9ABCDEF0);
    b = cx(32'h12345678, 32'h9ABCDEF0);
    step();
    chk("eq_y", y_d, 0);
    a = cx(32'hDEADBEEF, 32'h00C0FFEE);
    b = 0;
    step();
    chk("bz_x", x_d, cx(32'hDEADBEEF, 32'h00C0FFEE));
    chk("bz_y", y_d, cx(32'hDEADBEEF, 32'h00C0FFEE));

    // column-0 streaming, back to back
    a = cx(32'd0, 0);
    b = cx(32'd16, 0);
    for (int n = 0; n < 16; n++) begin
      step();
      chk($sformatf("str_ov%0d", n), ov_d, 1);
      chk($sformatf("str_x%0d", n),  x_d,  cx(32'(2*n + 16), 0));
      chk($sformatf("str_y%0d", n),  y_d,  cx(32'hFFFFFFF0, 0));
      if (n < 15) begin
        a = cx(32'(n + 1), 0);
        b = cx(32'(n + 17), 0);
      end else begin
        in_valid = 1'b0;
        a = cx(32'd999, 0);
      end
    end
    step();
    chk("str_end_ov", ov_d, 0);
    chk("str_end_x",  x_d,  cx(32'd46, 0));

    // gap pattern 1,0,1
    in_valid = 1'b1;
    a = cx(32'd100, 32'd1);
    b = cx(32'd40,  32'd2);
    step();
    chk("gap_ov1", ov_d, 1);
    chk("gap_x1",  x_d,  cx(32'd140, 32'd3));
    in_valid = 1'b0;
    a = cx(32'd7, 32'd7);
    b = cx(32'h7FFFFFFF, 0);
    step();
    chk("gap_ov0",  ov_d, 0);
    chk("gap_hold_x", x_d, cx(32'd140, 32'd3));
    chk("gap_hold_y", y_d, cx(32'd60, 32'hFFFFFFFF));
    chk("gap_hold_f", f_d, 0);
    in_valid = 1'b1;
    a = cx(32'd9, 0);
    b = cx(32'd4, 0);
    step();
    chk("gap_ov2", ov_d, 1);
    chk("gap_x2",  x_d,  cx(32'd13, 0));

    // async reset between edges while out_valid is high
    a = cx(32'h7FFFFFFF, 0);
    b = cx(32'd1, 0);
    step();
    chk("ar_pre_ov", ov_d, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ov",  ov_d, 0);
    chk("ar_x",   x_d,  0);
    chk("ar_y",   y_d,  0);
    chk("ar_ovf", f_d,  0);
    a = cx(32'd20, 32'd5);
    b = cx(32'd6,  32'd1);
    rst_n = 1'b1;
    step();
    chk("ar_post_ov", ov_d, 1);
    chk("ar_post_x",  x_d,  cx(32'd26, 32'd6));
    chk("ar_post_y",  y_d,  cx(32'd14, 32'd4));
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
